// File: rtl/display_timing_pkg.sv
// Default 640x480@60 timing constants and helpers shared by the display timing generator.
package display_timing_pkg;

    localparam int DEF_PIX_DIV  = 2;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    typedef struct packed {
        logic de;
        logic hsync;
        logic vsync;
    } timing_t;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Width needed to count 0..total-1, never less than one bit.
    function automatic int cnt_width(input int total);
        return (total <= 2) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/display_delay_line.sv
// Fixed-depth shift register with synchronous active-low reset to a programmable value.
module display_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/display_timing_gen.sv
// Display timing source: pixel/line/frame strobes, field flag and sync-aligned pixel output.
// Optional build macro DISPLAY_TEST_PATTERN_EN enables the h^v test pattern override.
module display_timing_gen
    import display_timing_pkg::*;
#(
    parameter int   PIX_DIV   = DEF_PIX_DIV,
    parameter int   H_ACTIVE  = DEF_H_ACTIVE,
    parameter int   H_FP      = DEF_H_FP,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BP      = DEF_H_BP,
    parameter int   V_ACTIVE  = DEF_V_ACTIVE,
    parameter int   V_FP      = DEF_V_FP,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BP      = DEF_V_BP,
    parameter logic HSYNC_POL = SYNC_ACTIVE_LOW,
    parameter logic VSYNC_POL = SYNC_ACTIVE_LOW
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       interlaced,
    input  logic       test_pattern,
    input  logic [7:0] display_data,
    output logic       display_next_pixel,
    output logic       display_next_line,
    output logic       display_next_frame,
    output logic       display_current_field,
    output logic [7:0] pix_index,
    output logic       vga_de,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic       vblank
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int H_W     = cnt_width(H_TOTAL);
    localparam int V_W     = cnt_width(V_TOTAL);
    localparam int D_W     = cnt_width(PIX_DIV);

    logic [D_W-1:0] div_cnt;
    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    int             h_pos;
    int             v_pos;
    logic           tick;
    logic           h_last;
    logic           v_last;
    logic           h_active;
    timing_t        timing_now;
    timing_t        timing_p0;
    timing_t        timing_p1;
    logic           capture_p1;
    logic [7:0]     capture_val;

    assign h_pos    = int'(h_cnt);
    assign v_pos    = int'(v_cnt);
    assign tick     = (div_cnt == D_W'(PIX_DIV - 1));
    assign h_last   = (h_pos == H_TOTAL - 1);
    assign v_last   = (v_pos == V_TOTAL - 1);
    assign h_active = (h_pos < H_ACTIVE);
    assign vblank   = (v_pos >= V_ACTIVE);

    assign timing_now.de    = h_active && (v_pos < V_ACTIVE);
    assign timing_now.hsync = (h_pos >= H_ACTIVE + H_FP && h_pos < H_ACTIVE + H_FP + H_SYNC)
                              ? HSYNC_POL : ~HSYNC_POL;
    assign timing_now.vsync = (v_pos >= V_ACTIVE + V_FP && v_pos < V_ACTIVE + V_FP + V_SYNC)
                              ? VSYNC_POL : ~VSYNC_POL;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // p0: strobes and per-pixel timing latched on the tick that ends the pixel slot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            display_next_pixel    <= 1'b0;
            display_next_line     <= 1'b0;
            display_next_frame    <= 1'b0;
            display_current_field <= 1'b0;
            capture_p1            <= 1'b0;
            timing_p0             <= '{de: 1'b0, hsync: ~HSYNC_POL, vsync: ~VSYNC_POL};
        end else begin
            display_next_pixel <= tick && h_active;
            display_next_line  <= tick && h_last;
            display_next_frame <= tick && h_last && v_last;
            capture_p1         <= display_next_pixel;
            if (tick) timing_p0 <= timing_now;
            if (tick && h_last && v_last)
                display_current_field <= interlaced ? ~display_current_field : 1'b0;
        end
    end

    // p1: timing waits one more clk so it lines up with the capture strobe
    display_delay_line #(
        .WIDTH   ($bits(timing_t)),
        .DEPTH   (1),
        .RST_VAL ({1'b0, ~HSYNC_POL, ~VSYNC_POL})
    ) u_timing_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (timing_p0),
        .dout  (timing_p1)
    );

`ifdef DISPLAY_TEST_PATTERN_EN
    logic [7:0] pattern_p0;
    logic [7:0] pattern_p1;

    always_ff @(posedge clk) begin
        if (tick) pattern_p0 <= h_pos[7:0] ^ v_pos[7:0];
        pattern_p1 <= pattern_p0;
    end

    assign capture_val = test_pattern ? pattern_p1 : display_data;
`else
    logic unused_test_pattern;
    assign unused_test_pattern = test_pattern;
    assign capture_val         = display_data;
`endif

    // p2: output register, all four video outputs change on the same edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_index <= 8'h00;
            vga_de    <= 1'b0;
            vga_hsync <= ~HSYNC_POL;
            vga_vsync <= ~VSYNC_POL;
        end else begin
            vga_de    <= timing_p1.de;
            vga_hsync <= timing_p1.hsync;
            vga_vsync <= timing_p1.vsync;
            if (!timing_p1.de)  pix_index <= 8'h00;
            else if (capture_p1) pix_index <= capture_val;
        end
    end

endmodule
